// File: rtl/boid_display_pkg.sv
// Shared constants and the frame-scheduler state encoding for the boid display path.
package boid_display_pkg;
    localparam int VIDEO_WIDTH  = 640;
    localparam int VIDEO_HEIGHT = 480;
    localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
    localparam int ADDR_W       = $clog2(PIXEL_COUNT) + 1;
    localparam int MAX_BOIDS    = 4;
    localparam int BOID_IDX_W   = $clog2(MAX_BOIDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWAP,
        ST_CLEAR,
        ST_PLOT,
        ST_DRAIN
    } sched_state_t;
endpackage

// File: rtl/boid_frame_scheduler_sweep_counter.sv
// Loadable up-counter that parks at LAST; last flags the terminal count.
module sweep_counter #(
    parameter int W    = 8,
    parameter int LAST = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign last  = (count_q == W'(LAST));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en && !last) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/boid_frame_scheduler.sv
// Per-frame sequencer: swap display buffers, clear the back buffer, then plot one pixel per boid.
module boid_frame_scheduler #(
    parameter int PIXEL_COUNT = boid_display_pkg::PIXEL_COUNT,
    parameter int MAX_BOIDS   = boid_display_pkg::MAX_BOIDS,
    parameter int BOID_IDX_W  = $clog2(MAX_BOIDS),
    parameter int ADDR_W      = $clog2(PIXEL_COUNT) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_end,
    input  logic [MAX_BOIDS-1:0]  boid_mask,
    output logic [BOID_IDX_W-1:0] boid_sel,
    input  logic [ADDR_W-1:0]     boid_addr,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  wr_data,
    output logic                  wr_buf,
    output logic                  disp_buf,
    output logic                  bpu_freeze,
    output logic                  busy,
    output logic                  overrun,
    output logic [15:0]           frame_count
);
    import boid_display_pkg::*;

    localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(PIXEL_COUNT);

    sched_state_t    state_q, state_d;
    logic            disp_buf_q, disp_buf_d;
    logic            wr_buf_q, wr_buf_d;
    logic            wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic            wr_data_q, wr_data_d;
    logic            freeze_q, freeze_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic [15:0]     frame_count_q, frame_count_d;

    logic                  clr_load, clr_en, clr_last;
    logic [ADDR_W-1:0]     clr_count;
    logic                  sel_load, sel_en, sel_last;
    logic [BOID_IDX_W-1:0] sel_count;
    logic                  plot_hit;

    sweep_counter #(.W(ADDR_W), .LAST(PIXEL_COUNT - 1)) u_clear_cnt (
        .clock (clock),
        .reset (reset),
        .load  (clr_load),
        .en    (clr_en),
        .count (clr_count),
        .last  (clr_last)
    );

    sweep_counter #(.W(BOID_IDX_W), .LAST(MAX_BOIDS - 1)) u_boid_cnt (
        .clock (clock),
        .reset (reset),
        .load  (sel_load),
        .en    (sel_en),
        .count (sel_count),
        .last  (sel_last)
    );

    // A boid is plotted only if enabled and its address lands inside the buffer.
    assign plot_hit = boid_mask[sel_count] && (boid_addr < PIX_LIMIT);

    always_comb begin
        state_d       = state_q;
        disp_buf_d    = disp_buf_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        freeze_d      = 1'b0;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;
        clr_load      = 1'b0;
        clr_en        = 1'b0;
        sel_load      = 1'b0;
        sel_en        = 1'b0;

        if (frame_end && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_end) begin
                    state_d    = ST_SWAP;
                    disp_buf_d = ~disp_buf_q;
                end
            end
            ST_SWAP: begin
                clr_load  = 1'b1;
                state_d   = ST_CLEAR;
                wr_en_d   = 1'b1;
                wr_data_d = 1'b0;
                wr_addr_d = '0;
            end
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (clr_last) begin
                    state_d  = ST_PLOT;
                    sel_load = 1'b1;
                    freeze_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = 1'b0;
                    wr_addr_d = clr_count + ADDR_W'(1);
                end
            end
            ST_PLOT: begin
                sel_en   = 1'b1;
                state_d  = sel_last ? ST_DRAIN : ST_PLOT;
                freeze_d = !sel_last;
                if (plot_hit) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = 1'b1;
                    wr_addr_d = boid_addr;
                end
            end
            ST_DRAIN: begin
                state_d       = ST_IDLE;
                frame_count_d = frame_count_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        wr_buf_d = ~disp_buf_d;
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            disp_buf_q    <= 1'b0;
            wr_buf_q      <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 1'b0;
            freeze_q      <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            disp_buf_q    <= disp_buf_d;
            wr_buf_q      <= wr_buf_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            freeze_q      <= freeze_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign boid_sel    = sel_count;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_buf      = wr_buf_q;
    assign disp_buf    = disp_buf_q;
    assign bpu_freeze  = freeze_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Scoreboard bench for boid_frame_scheduler at PIXEL_COUNT=16, MAX_BOIDS=4.
module tb_boid_frame_scheduler;
    localparam int PIX = 16;
    localparam int NB  = 4;
    localparam int AW  = 5;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_end = 1'b0;
    logic [NB-1:0] boid_mask = '0;
    logic [IW-1:0] boid_sel;
    logic [AW-1:0] boid_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          wr_buf;
    logic          disp_buf;
    logic          bpu_freeze;
    logic          busy;
    logic          overrun;
    logic [15:0]   frame_count;

    logic [AW-1:0] bpu_addr [NB];

    typedef struct {
        int           cyc;
        logic [AW-1:0] addr;
        logic         data;
    } wr_t;
    wr_t sb[$];

    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        exp_disp = 1'b0;
    logic        exp_overrun = 1'b0;
    logic [15:0] exp_frames = '0;

    boid_frame_scheduler #(
        .PIXEL_COUNT (PIX),
        .MAX_BOIDS   (NB),
        .BOID_IDX_W  (IW),
        .ADDR_W      (AW)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .frame_end   (frame_end),
        .boid_mask   (boid_mask),
        .boid_sel    (boid_sel),
        .boid_addr   (boid_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_buf      (wr_buf),
        .disp_buf    (disp_buf),
        .bpu_freeze  (bpu_freeze),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BPU address mux model: combinational lookup by the select index.
    assign boid_addr = bpu_addr[boid_sel];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check_val("wr_buf_inv", wr_buf, !disp_buf);
            if (wr_en) begin
                wr_t e;
                $display("wr cyc=%0d addr=%0d data=%0d buf=%0d", cyc, wr_addr, wr_data, wr_buf);
                check_val("wr_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_val("wr_cycle", cyc, e.cyc);
                    check_val("wr_addr", wr_addr, e.addr);
                    check_val("wr_data", wr_data, e.data);
                end
            end
        end
    end

    // Runs one frame: extra_at drives a second pulse at that offset, rst_at resets mid-frame.
    task automatic run_frame(input logic [NB-1:0] mask, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                             input int extra_at, input int rst_at);
        int base;
        logic [AW-1:0] addrs [NB];
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2; addrs[3] = a3;
        for (int k = 0; k < NB; k++) bpu_addr[k] = addrs[k];
        boid_mask = mask;
        @(negedge clk);
        base = cyc;
        frame_end = 1'b1;
        for (int a = 0; a < PIX; a++) sb.push_back('{base + 2 + a, AW'(a), 1'b0});
        for (int k = 0; k < NB; k++)
            if (mask[k] && addrs[k] < AW'(PIX)) sb.push_back('{base + 19 + k, addrs[k], 1'b1});
        exp_disp = ~exp_disp;
        $display("frame start cyc=%0d mask=%b addrs=%0d,%0d,%0d,%0d", base, mask, a0, a1, a2, a3);
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            frame_end = (i == extra_at);
            if (i == extra_at) exp_overrun = 1'b1;
            if (rst_at != 0 && i == rst_at + 1) begin
                reset = 1'b0;
                sb.delete();
                exp_disp = 1'b0;
                exp_frames = '0;
                exp_overrun = 1'b0;
                check_val("rst_wr_en", wr_en, 0);
                check_val("rst_busy", busy, 0);
                check_val("rst_disp_buf", disp_buf, 0);
                check_val("rst_frame_count", frame_count, 0);
                check_val("rst_boid_sel", boid_sel, 0);
                check_val("rst_freeze", bpu_freeze, 0);
                check_val("rst_overrun", overrun, 0);
                return;
            end
            check_val("busy", busy, (i <= 22));
            check_val("bpu_freeze", bpu_freeze, (i >= 18 && i <= 21));
            check_val("disp_buf", disp_buf, exp_disp);
            if (i >= 18 && i <= 21) check_val("boid_sel", boid_sel, i - 18);
            if (i == rst_at) reset = 1'b1;
        end
        exp_frames = exp_frames + 16'd1;
        check_val("frame_count", frame_count, exp_frames);
        check_val("overrun", overrun, exp_overrun);
        check_val("sb_drained", sb.size(), 0);
    endtask

    initial begin
        for (int k = 0; k < NB; k++) bpu_addr[k] = '0;
        repeat (3) @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_wr_en", wr_en, 0);
        check_val("reset_disp_buf", disp_buf, 0);
        check_val("reset_boid_sel", boid_sel, 0);
        check_val("reset_overrun", overrun, 0);
        check_val("reset_frame_count", frame_count, 0);
        check_val("reset_freeze", bpu_freeze, 0);
        reset = 1'b0;
        @(negedge clk);

        run_frame(4'b1111, 5'd3, 5'd7, 5'd7, 5'd15, 0, 0);
        run_frame(4'b0101, 5'd2, 5'd9, 5'd20, 5'd5, 0, 0);
        run_frame(4'b1111, 5'd0, 5'd16, 5'd31, 5'd1, 12, 0);
        run_frame(4'b1010, 5'd1, 5'd4, 5'd17, 5'd14, 0, 0);
        run_frame(4'b0011, 5'd8, 5'd15, 5'd2, 5'd3, 22, 0);
        repeat (2) @(negedge clk);
        check_val("idle_overrun", overrun, exp_overrun);

        run_frame(4'b1111, 5'd3, 5'd7, 5'd7, 5'd15, 0, 20);
        @(negedge clk);
        run_frame(4'b1001, 5'd6, 5'd6, 5'd6, 5'd12, 0, 0);

        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        exp_frames = 16'hFFFF;
        check_val("preload_frame_count", frame_count, exp_frames);
        run_frame(4'b1100, 5'd1, 5'd2, 5'd10, 5'd11, 0, 0);
        check_val("wrap_zero", frame_count, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
